// File: rtl/ysyx_040066_csr_trap.sv
// Machine-mode CSR file with trap/return sequencing for a single hart.
// Holds mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip and mhartid.
// Takes synchronous exceptions and M-mode interrupts, and executes mret.
// Each of these issues a one-cycle redirect (jmp/nxtpc).
// Optional feature macro: CSR_COUNTERS_EN adds mcycle (0xB00) and minstret (0xB02).
module ysyx_040066_csr_trap #(
  parameter int XLEN        = 64,
  parameter int VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_rd_addr,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            csr_rd_err,
  input  logic            csr_wen,
  input  logic [11:0]     csr_wr_addr,
  input  logic [XLEN-1:0] csr_wr_data,
  output logic            csr_wr_err,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] pc,
  input  logic            ret,
  input  logic            int_window,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  input  logic            retire,
  output logic            busy,
  output logic            jmp,
  output logic [XLEN-1:0] nxtpc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  // Fixed mstatus image: MPP=11, plus SXL/UXL=2 on RV64; bits 7 and 3 are zero here.
  localparam logic [63:0] MSTATUS_RST64 = (XLEN == 64) ? 64'h0000_000A_0000_1800
                                                       : 64'h0000_0000_0000_1800;

  typedef enum logic [1:0] {IDLE = 2'd0, TRAP = 2'd1, RET = 2'd2} state_t;

  state_t state, state_nxt;

  logic            mie_b, mpie_b;
  logic [XLEN-1:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
  logic            msip_p1, mtip_p1, meip_p1;
  logic [XLEN-1:0] mstatus_rd, mip_rd;
  logic            int_pend, trap_take, ret_take, wr_do;
  logic [3:0]      int_code;
  logic [XLEN-1:0] trap_base, trap_off;

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle_r, minstret_r;
`else
  logic            unused_retire;
  assign unused_retire = retire;
`endif

  // Addresses a CSR instruction may legally write.
  function automatic logic is_writable(input logic [11:0] a);
    logic ok;
    ok = (a == A_MSTATUS) || (a == A_MIE) || (a == A_MTVEC) || (a == A_MSCRATCH) ||
         (a == A_MEPC) || (a == A_MCAUSE) || (a == A_MTVAL);
`ifdef CSR_COUNTERS_EN
    ok = ok || (a == A_MCYCLE) || (a == A_MINSTRET);
`endif
    return ok;
  endfunction

  assign mstatus_rd = {MSTATUS_RST64[XLEN-1:8], mpie_b, MSTATUS_RST64[6:4], mie_b,
                       MSTATUS_RST64[2:0]};

  // Assemble mip from the registered interrupt lines; all other bits read zero.
  always_comb begin
    mip_rd     = '0;
    mip_rd[3]  = msip_p1;
    mip_rd[7]  = mtip_p1;
    mip_rd[11] = meip_p1;
  end

  // Pending-interrupt detection with MEI > MSI > MTI priority.
  always_comb begin
    logic [XLEN-1:0] act;
    act      = mip_rd & mie_r;
    int_code = 4'd0;
    if (act[11])     int_code = 4'd11;
    else if (act[3]) int_code = 4'd3;
    else if (act[7]) int_code = 4'd7;
    int_pend = int_window && mie_b && (act != '0);
  end

  assign trap_take = (state == IDLE) && (exc_valid || int_pend);
  assign ret_take  = (state == IDLE) && ret && !trap_take;
  assign wr_do     = (state == IDLE) && csr_wen && !csr_wr_err && !trap_take && !ret_take;

  assign csr_wr_err = csr_wen && !is_writable(csr_wr_addr);

  // Combinational CSR read with write-data forwarding.
  always_comb begin
    csr_rd_data = '0;
    csr_rd_err  = 1'b0;
    case (csr_rd_addr)
      A_MSTATUS:  csr_rd_data = mstatus_rd;
      A_MIE:      csr_rd_data = mie_r;
      A_MTVEC:    csr_rd_data = mtvec_r;
      A_MSCRATCH: csr_rd_data = mscratch_r;
      A_MEPC:     csr_rd_data = mepc_r;
      A_MCAUSE:   csr_rd_data = mcause_r;
      A_MTVAL:    csr_rd_data = mtval_r;
      A_MIP:      csr_rd_data = mip_rd;
      A_MHARTID:  csr_rd_data = '0;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:   csr_rd_data = mcycle_r;
      A_MINSTRET: csr_rd_data = minstret_r;
`endif
      default:    csr_rd_err  = 1'b1;
    endcase
    if (csr_wen && (csr_wr_addr == csr_rd_addr)) csr_rd_data = csr_wr_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: TRAP and RET each last exactly one cycle.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (trap_take)     state_nxt = TRAP;
        else if (ret_take) state_nxt = RET;
        else               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Trap target: direct base, or base + 4*code for vectored interrupts.
  always_comb begin
    trap_base = {mtvec_r[XLEN-1:2], 2'b00};
    trap_off  = '0;
    if ((VECTORED_EN != 0) && (mtvec_r[1:0] == 2'b01) && mcause_r[XLEN-1])
      trap_off = {mcause_r[XLEN-3:0], 2'b00};
  end

  // Redirect outputs driven from the current state.
  always_comb begin
    busy  = (state != IDLE);
    jmp   = 1'b0;
    nxtpc = '0;
    case (state)
      TRAP: begin
        jmp   = 1'b1;
        nxtpc = trap_base + trap_off;
      end
      RET: begin
        jmp   = 1'b1;
        nxtpc = mepc_r;
      end
      default: begin
        jmp   = 1'b0;
        nxtpc = '0;
      end
    endcase
  end

  // CSR state: trap/ret side effects take precedence over instruction writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_b      <= 1'b0;
      mpie_b     <= 1'b0;
      mie_r      <= '0;
      mtvec_r    <= '0;
      mscratch_r <= '0;
      mepc_r     <= '0;
      mcause_r   <= '0;
      mtval_r    <= '0;
      msip_p1    <= 1'b0;
      mtip_p1    <= 1'b0;
      meip_p1    <= 1'b0;
    end else begin
      msip_p1 <= irq_msip;
      mtip_p1 <= irq_mtip;
      meip_p1 <= irq_meip;
      if (trap_take) begin
        mepc_r <= pc;
        if (exc_valid) begin
          mcause_r <= exc_cause;
          mtval_r  <= exc_tval;
        end else begin
          mcause_r <= {1'b1, {(XLEN-5){1'b0}}, int_code};
          mtval_r  <= '0;
        end
        mpie_b <= mie_b;
        mie_b  <= 1'b0;
      end else if (ret_take) begin
        mie_b  <= mpie_b;
        mpie_b <= 1'b1;
      end else if (wr_do) begin
        case (csr_wr_addr)
          A_MSTATUS: begin
            mie_b  <= csr_wr_data[3];
            mpie_b <= csr_wr_data[7];
          end
          A_MIE:      mie_r      <= csr_wr_data;
          A_MTVEC:    mtvec_r    <= csr_wr_data;
          A_MSCRATCH: mscratch_r <= csr_wr_data;
          A_MEPC:     mepc_r     <= csr_wr_data;
          A_MCAUSE:   mcause_r   <= csr_wr_data;
          A_MTVAL:    mtval_r    <= csr_wr_data;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // Free-running counters; an instruction write overrides that cycle's increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_r   <= '0;
      minstret_r <= '0;
    end else begin
      if (wr_do && (csr_wr_addr == A_MCYCLE)) mcycle_r <= csr_wr_data;
      else                                    mcycle_r <= mcycle_r + 1'b1;
      if (wr_do && (csr_wr_addr == A_MINSTRET)) minstret_r <= csr_wr_data;
      else if (retire)                          minstret_r <= minstret_r + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_040066_csr_trap.sv
// Directed bench for ysyx_040066_csr_trap (XLEN=64, vectored mode enabled).
module tb_ysyx_040066_csr_trap;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] csr_rd_addr = '0;
  logic [63:0] csr_rd_data;
  logic        csr_rd_err;
  logic        csr_wen = 1'b0;
  logic [11:0] csr_wr_addr = '0;
  logic [63:0] csr_wr_data = '0;
  logic        csr_wr_err;
  logic        exc_valid = 1'b0;
  logic [63:0] exc_cause = '0;
  logic [63:0] exc_tval = '0;
  logic [63:0] pc = '0;
  logic        ret = 1'b0;
  logic        int_window = 1'b0;
  logic        irq_msip = 1'b0;
  logic        irq_mtip = 1'b0;
  logic        irq_meip = 1'b0;
  logic        retire = 1'b0;
  logic        busy;
  logic        jmp;
  logic [63:0] nxtpc;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_040066_csr_trap #(.XLEN(64), .VECTORED_EN(1)) dut (
    .clk(clk), .rst(rst),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_rd_err(csr_rd_err),
    .csr_wen(csr_wen), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_wr_err(csr_wr_err),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .pc(pc),
    .ret(ret), .int_window(int_window),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .retire(retire), .busy(busy), .jmp(jmp), .nxtpc(nxtpc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [63:0] exp);
    csr_rd_addr = a;
    #1;
    chk(tag, csr_rd_data, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_wen     = 1'b1;
    csr_wr_addr = a;
    csr_wr_data = d;
    step();
    csr_wen = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b1;
    #1;

    // Reset state
    rd(12'h300, "rst_mstatus", 64'h0000_000A_0000_1800);
    chk("rst_rd_err", {63'd0, csr_rd_err}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_jmp", {63'd0, jmp}, 64'd0);
    chk("rst_nxtpc", nxtpc, 64'd0);
    rd(12'h341, "rst_mepc", 64'd0);
    rd(12'h7C0, "unimpl_rd_data", 64'd0);
    chk("unimpl_rd_err", {63'd0, csr_rd_err}, 64'd1);
    rd(12'hF14, "mhartid", 64'd0);
    chk("mhartid_err", {63'd0, csr_rd_err}, 64'd0);

    // Forwarding of an in-flight write to the read port
    csr_wen = 1'b1; csr_wr_addr = 12'h305; csr_wr_data = 64'h8000_0000;
    rd(12'h305, "fwd_mtvec", 64'h8000_0000);
    chk("wr_err_ok", {63'd0, csr_wr_err}, 64'd0);
    step();
    csr_wen = 1'b0;
    rd(12'h305, "mtvec_stored", 64'h8000_0000);

    // Read-only mip write is flagged
    csr_wen = 1'b1; csr_wr_addr = 12'h344; csr_wr_data = 64'hFFFF;
    #1;
    chk("mip_wr_err", {63'd0, csr_wr_err}, 64'd1);
    step();
    csr_wen = 1'b0;
    rd(12'h344, "mip_unchanged", 64'd0);

    // Synchronous exception
    exc_valid = 1'b1; exc_cause = 64'd2; pc = 64'h100; exc_tval = 64'hDEAD;
    #1;
    chk("exc_idle_jmp", {63'd0, jmp}, 64'd0);
    step();
    exc_valid = 1'b0;
    #1;
    chk("exc_jmp", {63'd0, jmp}, 64'd1);
    chk("exc_nxtpc", nxtpc, 64'h8000_0000);
    chk("exc_busy", {63'd0, busy}, 64'd1);
    // Write attempted while busy must be ignored
    wr(12'h340, 64'h55);
    chk("exc_jmp_off", {63'd0, jmp}, 64'd0);
    chk("exc_nxtpc_off", nxtpc, 64'd0);
    rd(12'h340, "busy_wr_ignored", 64'd0);
    rd(12'h341, "exc_mepc", 64'h100);
    rd(12'h342, "exc_mcause", 64'd2);
    rd(12'h343, "exc_mtval", 64'hDEAD);
    rd(12'h300, "exc_mstatus", 64'h0000_000A_0000_1800);

    // Vectored interrupt, MEI wins over MTI
    wr(12'h305, 64'h8000_0001);
    wr(12'h304, 64'h888);
    wr(12'h300, 64'h8);
    rd(12'h300, "mstatus_mie_set", 64'h0000_000A_0000_1808);
    irq_mtip = 1'b1; irq_meip = 1'b1; pc = 64'h300;
    step();
    rd(12'h344, "mip_lines", 64'h880);
    chk("no_window_busy", {63'd0, busy}, 64'd0);
    int_window = 1'b1;
    step();
    int_window = 1'b0;
    irq_mtip = 1'b0; irq_meip = 1'b0;
    #1;
    chk("irq_jmp", {63'd0, jmp}, 64'd1);
    chk("irq_nxtpc", nxtpc, 64'h8000_002C);
    step();
    rd(12'h342, "irq_mcause", 64'h8000_0000_0000_000B);
    rd(12'h343, "irq_mtval", 64'd0);
    rd(12'h341, "irq_mepc", 64'h300);
    rd(12'h300, "irq_mstatus", 64'h0000_000A_0000_1880);

    // mret
    wr(12'h341, 64'h200);
    ret = 1'b1;
    step();
    ret = 1'b0;
    #1;
    chk("ret_jmp", {63'd0, jmp}, 64'd1);
    chk("ret_nxtpc", nxtpc, 64'h200);
    step();
    chk("ret_jmp_off", {63'd0, jmp}, 64'd0);
    rd(12'h300, "ret_mstatus", 64'h0000_000A_0000_1888);

    // ret together with an exception: trap wins
    exc_valid = 1'b1; exc_cause = 64'd5; pc = 64'h400; exc_tval = 64'h11; ret = 1'b1;
    step();
    exc_valid = 1'b0; ret = 1'b0;
    #1;
    chk("both_jmp", {63'd0, jmp}, 64'd1);
    chk("both_nxtpc", nxtpc, 64'h8000_0000);
    step();
    rd(12'h341, "both_mepc", 64'h400);
    rd(12'h342, "both_mcause", 64'd5);
    rd(12'h300, "both_mstatus", 64'h0000_000A_0000_1880);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rd(12'hB00, "mcycle_wrap", 64'd0);
    chk("mcycle_err", {63'd0, csr_rd_err}, 64'd0);
    wr(12'hB02, 64'd5);
    retire = 1'b1;
    step();
    retire = 1'b0;
    step();
    rd(12'hB02, "minstret_inc", 64'd6);
`else
    rd(12'hB00, "mcycle_absent", 64'd0);
    chk("mcycle_rd_err", {63'd0, csr_rd_err}, 64'd1);
    csr_wen = 1'b1; csr_wr_addr = 12'hB02; csr_wr_data = 64'd1;
    #1;
    chk("minstret_wr_err", {63'd0, csr_wr_err}, 64'd1);
    step();
    csr_wen = 1'b0;
`endif

    // Reset asserted during TRAP
    wr(12'h341, 64'h1234);
    exc_valid = 1'b1; exc_cause = 64'd3; pc = 64'h500;
    step();
    exc_valid = 1'b0;
    #1;
    chk("pre_rst_jmp", {63'd0, jmp}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_jmp", {63'd0, jmp}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_nxtpc", nxtpc, 64'd0);
    rd(12'h341, "rst_mid_mepc", 64'd0);
    rd(12'h300, "rst_mid_mstatus", 64'h0000_000A_0000_1800);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_jmp", {63'd0, jmp}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
